// File: rtl/llr_stream_buffer.sv
// llr_stream_buffer: output stage of the ML demodulator. Saturates a block of
// N_BITS soft-bit LLRs to LLR_OUT_W bits on each i_trig pulse, buffers up to DEPTH
// blocks and streams them one LLR per o_rd_vld/i_rd_rdy handshake. The hard bit is
// the LLR sign.
// Optional feature macro: ML_LLR_ZERO_SUB_EN (a saturated 0 is stored as +1).
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_trig, i_llr_vec     block strobe and N_BITS packed signed LLRs
//   o_trig_rdy            buffer not full
//   o_overflow            sticky: block dropped because buffer was full
//   o_level               blocks stored, including a partially read head
//   i_rd_rdy, o_rd_vld    read handshake
//   o_llr, o_hard_bit     current saturated LLR and its sign
//   o_blk_last            current LLR is the last of its block
module llr_stream_buffer #(
    parameter int unsigned N_BITS    = 8,
    parameter int unsigned LLR_IN_W  = 12,
    parameter int unsigned LLR_OUT_W = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_trig,
    input  logic [N_BITS*LLR_IN_W-1:0]      i_llr_vec,
    output logic                            o_trig_rdy,
    output logic                            o_overflow,
    output logic [$clog2(DEPTH):0]          o_level,
    input  logic                            i_rd_rdy,
    output logic                            o_rd_vld,
    output logic [LLR_OUT_W-1:0]            o_llr,
    output logic                            o_hard_bit,
    output logic                            o_blk_last
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(N_BITS);
    localparam int unsigned BLK_W = N_BITS * LLR_OUT_W;

    localparam logic signed [LLR_IN_W-1:0] SAT_MAX = LLR_IN_W'((2 ** (LLR_OUT_W - 1)) - 1);
    localparam logic signed [LLR_IN_W-1:0] SAT_MIN = -SAT_MAX;
    localparam logic [IDX_W-1:0]           IDX_LAST = IDX_W'(N_BITS - 1);
    localparam logic [LVL_W-1:0]           LVL_FULL = LVL_W'(DEPTH);

    // Symmetric clamp; the most-negative output code is never produced.
    function automatic logic [LLR_OUT_W-1:0] saturate(input logic signed [LLR_IN_W-1:0] x);
        logic signed [LLR_IN_W-1:0] c;
        if (x > SAT_MAX) begin
            c = SAT_MAX;
        end else if (x < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = x;
        end
`ifdef ML_LLR_ZERO_SUB_EN
        if (c == '0) begin
            c = LLR_IN_W'(1);
        end
`endif
        return LLR_OUT_W'(c);
    endfunction

    logic [BLK_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]     rd_ptr, rd_ptr_n;
    logic [LVL_W-1:0]     level, level_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 overflow, overflow_n;
    logic                 trig_rdy, trig_rdy_n;
    logic                 rd_vld, rd_vld_n;
    logic [LLR_OUT_W-1:0] llr, llr_n;
    logic                 blk_last, blk_last_n;
    logic [BLK_W-1:0]     sat_blk;
    logic [BLK_W-1:0]     head_blk;
    logic                 push, pop, xfer;

    // Saturate all incoming lanes in parallel.
    always_comb begin
        sat_blk = '0;
        for (int k = 0; k < int'(N_BITS); k++) begin
            sat_blk[k*LLR_OUT_W +: LLR_OUT_W] = saturate(i_llr_vec[k*LLR_IN_W +: LLR_IN_W]);
        end
    end

    // Next-state and next-output computation; outputs are registered from this.
    always_comb begin
        push       = i_trig & trig_rdy;
        xfer       = rd_vld & i_rd_rdy;
        pop        = xfer && (bit_idx == IDX_LAST);
        wr_ptr_n   = wr_ptr + PTR_W'(push);
        rd_ptr_n   = rd_ptr + PTR_W'(pop);
        level_n    = level + LVL_W'(push) - LVL_W'(pop);
        overflow_n = overflow | (i_trig & ~trig_rdy);
        bit_idx_n  = bit_idx;
        if (xfer) begin
            bit_idx_n = pop ? '0 : bit_idx + IDX_W'(1);
        end
        // A block written into an empty (or just emptied) buffer becomes the head
        // at this edge, so forward it instead of reading the not-yet-written slot.
        head_blk   = (push && (level == LVL_W'(pop))) ? sat_blk : mem[rd_ptr_n];
        rd_vld_n   = (level_n != '0);
        trig_rdy_n = (level_n != LVL_FULL);
        llr_n      = '0;
        blk_last_n = 1'b0;
        if (rd_vld_n) begin
            llr_n      = head_blk[int'(bit_idx_n)*LLR_OUT_W +: LLR_OUT_W];
            blk_last_n = (bit_idx_n == IDX_LAST);
        end
    end

    // Block storage; contents need no reset since level gates visibility.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push) begin
            mem[wr_ptr] <= sat_blk;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            bit_idx  <= '0;
            overflow <= 1'b0;
            trig_rdy <= 1'b1;
            rd_vld   <= 1'b0;
            llr      <= '0;
            blk_last <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            bit_idx  <= bit_idx_n;
            overflow <= overflow_n;
            trig_rdy <= trig_rdy_n;
            rd_vld   <= rd_vld_n;
            llr      <= llr_n;
            blk_last <= blk_last_n;
        end
    end

    assign o_trig_rdy = trig_rdy;
    assign o_overflow = overflow;
    assign o_level    = level;
    assign o_rd_vld   = rd_vld;
    assign o_llr      = llr;
    assign o_hard_bit = llr[LLR_OUT_W-1];
    assign o_blk_last = blk_last;

endmodule

// File: tb/tb_llr_stream_buffer.sv
// Self-checking bench for llr_stream_buffer (default parameters). A scoreboard
// queue holds the expected LLR stream; a negedge monitor compares DUT outputs
// against the queue head and a small level/overflow model every cycle.
module tb_llr_stream_buffer;

    localparam int NB = 8;
    localparam int IW = 12;
    localparam int OW = 8;
    localparam int DP = 4;

    typedef struct {
        logic [OW-1:0] llr;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trig = 1'b0;
    logic [NB*IW-1:0] llr_vec = '0;
    logic             rd_rdy = 1'b0;
    logic             trig_rdy, overflow, rd_vld, hard_bit, blk_last;
    logic [2:0]       level;
    logic [OW-1:0]    llr;

    exp_t sb[$];
    int   lanes[NB];
    int   mlevel = 0;
    logic movf = 1'b0;
    bit   mon_en = 1'b0;
    bit   rnd_rdy = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    llr_stream_buffer #(.N_BITS(NB), .LLR_IN_W(IW), .LLR_OUT_W(OW), .DEPTH(DP)) dut (
        .i_clk(clk), .i_reset(rst), .i_trig(trig), .i_llr_vec(llr_vec),
        .o_trig_rdy(trig_rdy), .o_overflow(overflow), .o_level(level),
        .i_rd_rdy(rd_rdy), .o_rd_vld(rd_vld), .o_llr(llr),
        .o_hard_bit(hard_bit), .o_blk_last(blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] sat8(input int x);
        int c;
        c = x;
        if (c > 127) c = 127;
        if (c < -127) c = -127;
`ifdef ML_LLR_ZERO_SUB_EN
        if (c == 0) c = 1;
`endif
        return OW'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) rd_rdy = ($urandom_range(0, 3) == 0);
    endtask

    // Present lanes[] for one cycle; the model decides acceptance from its own level.
    task automatic send_block();
        bit acc;
        for (int k = 0; k < NB; k++) llr_vec[k*IW +: IW] = IW'(lanes[k]);
        trig = 1'b1;
        acc  = (mlevel != DP);
        step();
        trig = 1'b0;
        if (acc) begin
            for (int k = 0; k < NB; k++) begin
                exp_t e;
                e.llr  = sat8(lanes[k]);
                e.last = (k == NB - 1);
                sb.push_back(e);
            end
            mlevel++;
        end else begin
            movf = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        mlevel = 0;
        movf   = 1'b0;
        check("rst_vld", 32'(rd_vld), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rdy", 32'(trig_rdy), 32'd1);
        check("rst_llr", 32'(llr), 32'd0);
        check("rst_hard", 32'(hard_bit), 32'd0);
        check("rst_last", 32'(blk_last), 32'd0);
    endtask

    // Per-cycle monitor: inputs settle at posedge+1, so the handshake seen here
    // is the one that happens at the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("level", 32'(level), 32'(mlevel));
            check("vld", 32'(rd_vld), 32'(mlevel != 0));
            check("trig_rdy", 32'(trig_rdy), 32'(mlevel != DP));
            check("ovf", 32'(overflow), 32'(movf));
            if (rd_vld) begin
                if (sb.size() == 0) begin
                    check("sb_underrun", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb[0];
                    check("llr", 32'(llr), 32'(e.llr));
                    check("hard", 32'(hard_bit), 32'(e.llr[OW-1]));
                    check("last", 32'(blk_last), 32'(e.last));
                    if (rd_rdy) begin
                        void'(sb.pop_front());
                        if (e.last) mlevel--;
                    end
                end
            end
        end
    end

    initial begin
        step();
        step();
        do_reset();
        mon_en = 1'b1;

        // Ramp block with continuous ready.
        rd_rdy = 1'b1;
        for (int k = 0; k < NB; k++) lanes[k] = k * 50 - 200;
        send_block();
        repeat (10) step();

        // Input extremes and near-boundary codes.
        lanes = '{2047, -2048, 0, 1, -1, 127, 128, -128};
        send_block();
        repeat (10) step();

        // Fill with ready low, hold 512 cycles, then overflow and drain.
        rd_rdy = 1'b0;
        for (int b = 0; b < DP; b++) begin
            for (int k = 0; k < NB; k++) lanes[k] = b * 100 + k * 37 - 300;
            send_block();
        end
        check("full_level", 32'(level), 32'd4);
        check("full_rdy", 32'(trig_rdy), 32'd0);
        repeat (512) step();
        for (int k = 0; k < NB; k++) lanes[k] = 999;
        send_block();
        check("ovf_set", 32'(overflow), 32'd1);
        rd_rdy = 1'b1;
        repeat (40) step();
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset after 3 of 8 LLRs with two further blocks queued.
        rd_rdy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < NB; k++) lanes[k] = k * 11 - b * 40;
            send_block();
        end
        rd_rdy = 1'b1;
        repeat (3) step();
        rd_rdy = 1'b0;
        do_reset();
        rd_rdy = 1'b1;
        for (int k = 0; k < NB; k++) lanes[k] = 20 - k * 9;
        send_block();
        repeat (10) step();

        // Push coinciding with the final-index pop at level 2.
        rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NB; k++) lanes[k] = 60 * b - k * 13;
            send_block();
        end
        rd_rdy = 1'b1;
        repeat (7) step();
        for (int k = 0; k < NB; k++) lanes[k] = -5 * k - 1;
        send_block();
        check("push_pop_level", 32'(level), 32'd2);
        repeat (30) step();

        // Long random-ready stream.
        rnd_rdy = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < NB; k++) lanes[k] = int'($urandom_range(0, 4095)) - 2048;
            send_block();
            repeat (63) step();
        end
        rnd_rdy = 1'b0;
        rd_rdy  = 1'b1;
        repeat (50) step();
        check("final_empty", 32'(sb.size()), 32'd0);
        check("final_no_ovf", 32'(overflow), 32'd0);
        check("final_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
